// File: rtl/logic_unit_pkg.sv
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared operation encoding for the pipelined logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

endpackage

`default_nettype wire

// File: rtl/logic_unit_pipe_if.sv
// ============================================================================
// Module      : logic_unit_pipe_if
// Description : Operand/result streaming bus for logic_unit_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_unit_pipe_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op;
    logic             acc_sel;
    logic             acc_clear;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outputC;
    logic             zero;

    // Operand source / result consumer side
    modport master (
        output in_valid, op, acc_sel, acc_clear, inputA, inputB, out_ready,
        input  in_ready, out_valid, outputC, zero
    );

    // Logic unit side
    modport slave (
        input  in_valid, op, acc_sel, acc_clear, inputA, inputB, out_ready,
        output in_ready, out_valid, outputC, zero
    );

endinterface

`default_nettype wire

// File: rtl/logic_unit_core.sv
// ============================================================================
// Module      : logic_unit_core
// Description : Combinational bitwise operation selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage valid/ready bitwise logic unit with zero flag.
//               Define LOGIC_UNIT_PIPE_ACCUM_EN to build the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    logic_unit_pipe_if.slave    bus
);

    logic             r_s1Valid;
    op_e              r_s1Op;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2C;
    logic             r_s2Zero;

    logic             w_inXfer;
    logic             w_outXfer;
    logic             w_adv;
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_y;

    assign w_adv     = r_s1Valid && (!r_s2Valid || bus.out_ready);
    assign w_outXfer = r_s2Valid && bus.out_ready;
    assign w_inXfer  = bus.in_valid && bus.in_ready;

    // Held low through reset so nothing is accepted into a pipe being flushed
    assign bus.in_ready  = !rst && (!r_s1Valid || w_adv);
    assign bus.out_valid = r_s2Valid;
    assign bus.outputC   = r_s2C;
    assign bus.zero      = r_s2Zero;

`ifdef LOGIC_UNIT_PIPE_ACCUM_EN
    logic             r_s1AccSel;
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1AccSel <= 1'b0;
        end else if (w_inXfer) begin
            r_s1AccSel <= bus.acc_sel;
        end
    end

    // Clear beats a coincident advance; the result itself still reaches S2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (bus.acc_clear) begin
            r_acc <= '0;
        end else if (w_adv) begin
            r_acc <= w_y;
        end
    end

    assign w_opA = r_s1AccSel ? r_acc : r_s1A;
`else
    assign w_opA = r_s1A;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Op    <= OP_AND;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else begin
            if (w_inXfer) begin
                r_s1Valid <= 1'b1;
                r_s1Op    <= op_e'(bus.op);
                r_s1A     <= bus.inputA;
                r_s1B     <= bus.inputB;
            end else if (w_adv) begin
                r_s1Valid <= 1'b0;
            end
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (r_s1Op),
        .a  (w_opA),
        .b  (r_s1B),
        .y  (w_y)
    );

    // Zero flag is dropped with out_valid so it never reports a stale result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2C     <= '0;
            r_s2Zero  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_s2Valid <= 1'b1;
                r_s2C     <= w_y;
                r_s2Zero  <= (w_y == '0);
            end else if (w_outXfer) begin
                r_s2Valid <= 1'b0;
                r_s2Zero  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Randomised and directed self-checking bench for logic_unit_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

`ifdef LOGIC_UNIT_PIPE_ACCUM_EN
    localparam bit C_ACC_EN = 1'b1;
`else
    localparam bit C_ACC_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    logic_unit_pipe_if #(.WIDTH(16)) bus ();

    logic_unit_pipe #(.WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nChecks;
    int          nPass;
    logic [15:0] expQ[$];
    logic [15:0] gotLog[$];
    logic [15:0] modelAcc;
    logic        prevHold;
    logic [15:0] prevC;
    logic        sInReady;
    logic        sOutValid;
    logic        sAccepted;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Each op is a 2-input truth table indexed by {a,b}
    function automatic logic [15:0] refOp(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [3:0] tt [8];
        logic [3:0] t;
        logic [15:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
        tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1010;
        t = tt[o];
        for (int i = 0; i < 16; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    task automatic doCycle(input logic v, input logic [2:0] o, input logic as, input logic ac,
                           input logic [15:0] a, input logic [15:0] b, input logic ordy);
        logic [15:0] e;
        logic [15:0] r;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op        = o;
        bus.acc_sel   = as;
        bus.acc_clear = ac;
        bus.inputA    = a;
        bus.inputB    = b;
        bus.out_ready = ordy;
        #1;
        sInReady  = bus.in_ready;
        sOutValid = bus.out_valid;
        if (prevHold) begin
            checkValue("holdValid", bus.out_valid, 1);
            checkValue("holdData", bus.outputC, prevC);
        end
        if (bus.out_valid && ordy) begin
            checkValue("beatExpected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkValue("outputC", bus.outputC, e);
                checkValue("zero", bus.zero, e == 16'h0);
            end
            gotLog.push_back(bus.outputC);
        end
        prevHold = bus.out_valid && !ordy;
        prevC    = bus.outputC;
        if (ac) modelAcc = 16'h0;
        sAccepted = v && sInReady;
        if (sAccepted) begin
            r = refOp(o, (C_ACC_EN && as) ? modelAcc : a, b);
            modelAcc = r;
            expQ.push_back(r);
        end
    endtask

    task automatic idle(input logic ordy);
        doCycle(1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, ordy);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (expQ.size() > 0 || sOutValid); i++) idle(1'b1);
        checkValue("drainTimeout", expQ.size(), 0);
        checkValue("drainValid", sOutValid, 0);
    endtask

    logic [15:0] streamExp [8];
    logic        curV;
    logic [2:0]  curOp;
    logic        curAs;
    logic [15:0] curA, curB;

    initial begin
        nChecks = 0; nPass = 0; modelAcc = 16'h0; prevHold = 1'b0; prevC = 16'h0;
        sInReady = 1'b0; sOutValid = 1'b0; sAccepted = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.acc_sel = 1'b0; bus.acc_clear = 1'b0;
        bus.inputA = 16'h0; bus.inputB = 16'h0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkValue("rstOutValid", bus.out_valid, 0);
        checkValue("rstOutputC", bus.outputC, 0);
        checkValue("rstZero", bus.zero, 0);
        checkValue("rstInReady", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkValue("postRstInReady", bus.in_ready, 1);

        // Latency: accept, one cycle in S1, then visible
        gotLog.delete();
        doCycle(1'b1, 3'd0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00, 1'b1);
        idle(1'b1);
        checkValue("latencyEarly", sOutValid, 0);
        idle(1'b1);
        checkValue("latencyValid", sOutValid, 1);
        checkValue("andResult", gotLog.size() > 0 ? gotLog[0] : 16'hDEAD, 16'hF000);
        drain();

        // All eight ops streamed back to back
        streamExp[0] = 16'h0034; streamExp[1] = 16'h12FF; streamExp[2] = 16'h12CB; streamExp[3] = 16'hFFCB;
        streamExp[4] = 16'hED00; streamExp[5] = 16'hED34; streamExp[6] = 16'hEDCB; streamExp[7] = 16'h00FF;
        gotLog.delete();
        for (int i = 0; i < 8; i++) doCycle(1'b1, 3'(i), 1'b0, 1'b0, 16'h1234, 16'h00FF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkValue("streamCount", gotLog.size(), 8);
        for (int i = 0; i < 8 && i < gotLog.size(); i++) checkValue("streamOp", gotLog[i], streamExp[i]);
        drain();

        // Back-pressure: third beat refused while both stages are full
        gotLog.delete();
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'h1111, 1'b0);
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'h2222, 1'b0);
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'h3333, 1'b0);
        checkValue("fullInReady", sInReady, 0);
        idle(1'b0);
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'h3333, 1'b1);
        checkValue("releaseInReady", sInReady, 1);
        drain();
        checkValue("bpCount", gotLog.size(), 3);
        if (gotLog.size() == 3) begin
            checkValue("bpOrder0", gotLog[0], 16'h1111);
            checkValue("bpOrder1", gotLog[1], 16'h2222);
            checkValue("bpOrder2", gotLog[2], 16'h3333);
        end

`ifdef LOGIC_UNIT_PIPE_ACCUM_EN
        gotLog.delete();
        doCycle(1'b0, 3'd0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'h00FF, 1'b1);
        doCycle(1'b1, 3'd1, 1'b1, 1'b0, 16'h0, 16'h0F00, 1'b1);
        doCycle(1'b1, 3'd2, 1'b1, 1'b0, 16'h0, 16'h0FFF, 1'b1);
        drain();
        checkValue("accCount", gotLog.size(), 3);
        if (gotLog.size() == 3) begin
            checkValue("acc0", gotLog[0], 16'h00FF);
            checkValue("acc1", gotLog[1], 16'h0FFF);
            checkValue("acc2", gotLog[2], 16'h0000);
        end
        // Clear coincides with the advance of PASSB 0xAAAA
        gotLog.delete();
        doCycle(1'b1, 3'd7, 1'b0, 1'b0, 16'h0, 16'hAAAA, 1'b1);
        doCycle(1'b0, 3'd0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
        doCycle(1'b1, 3'd1, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        drain();
        checkValue("clrCount", gotLog.size(), 2);
        if (gotLog.size() == 2) begin
            checkValue("clrPass", gotLog[0], 16'hAAAA);
            checkValue("clrNext", gotLog[1], 16'h0000);
        end
`endif

        // Randomised traffic with random back-pressure
        curV = 1'b0; curOp = 3'd0; curAs = 1'b0; curA = 16'h0; curB = 16'h0;
        for (int i = 0; i < 500; i++) begin
            if (!curV || sAccepted) begin
                curV  = ($urandom % 4) != 0;
                curOp = 3'($urandom % 8);
                curAs = 1'($urandom % 2);
                curA  = 16'($urandom);
                curB  = ($urandom % 8 == 0) ? curA : 16'($urandom);
            end
            doCycle(curV, curOp, curAs, 1'b0, curA, curB, ($urandom % 3) != 0);
        end
        drain();

        // Reset with both stages full
        doCycle(1'b1, 3'd1, 1'b0, 1'b0, 16'h5A5A, 16'h0101, 1'b0);
        doCycle(1'b1, 3'd1, 1'b0, 1'b0, 16'h5A5A, 16'h0202, 1'b0);
        idle(1'b0);
        checkValue("preRstFull", sOutValid, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checkValue("midRstOutValid", bus.out_valid, 0);
        checkValue("midRstOutputC", bus.outputC, 0);
        checkValue("midRstInReady", bus.in_ready, 0);
        checkValue("midRstZero", bus.zero, 0);
        expQ.delete();
        modelAcc = 16'h0;
        prevHold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkValue("afterRstInReady", bus.in_ready, 1);
        sOutValid = bus.out_valid;
        doCycle(1'b1, 3'd5, 1'b0, 1'b0, 16'h00FF, 16'h0F0F, 1'b1);
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
